// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, pixel and coordinate types
// Contents: 640x480@60 timing constants (*_DEF), line/frame totals,
// TRANSPARENT colour key, pixel_t (RGB332) and coord_t (10-bit).
package vga_pkg;
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef logic [7:0] pixel_t;
    typedef logic [9:0] coord_t;

    localparam pixel_t TRANSPARENT = 8'hFC;
endpackage

// File: rtl/vga_scan_timing_if.sv
// rtl/vga_scan_timing_if.sv - scan timing outputs bundled for the selector/connector
// Signals: pix_en, x_ptr, y_ptr, video_on, hsync, vsync, frame_tick, anim_phase.
// Modports: master (timing generator drives), slave (selector/connector reads).
interface vga_scan_timing_if;
    import vga_pkg::*;

    logic   pix_en;
    coord_t x_ptr;
    coord_t y_ptr;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   frame_tick;
    logic   anim_phase;

    modport master (
        output pix_en, x_ptr, y_ptr, video_on, hsync, vsync, frame_tick, anim_phase
    );
    modport slave (
        input  pix_en, x_ptr, y_ptr, video_on, hsync, vsync, frame_tick, anim_phase
    );
endinterface

// File: rtl/vga_sync_delay.sv
// rtl/vga_sync_delay.sv - DEPTH-stage shift register for {hsync, vsync, video_on}
// Ports: clk, rst_n (async active-low), din[2:0], dout[2:0] = {hsync, vsync, video_on}.
// DEPTH=0 is a combinational pass-through; stages reset to {1,1,0} (syncs idle high).
module vga_sync_delay #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] din,
    output logic [2:0] dout
);
    localparam logic [2:0] IDLE = 3'b110;

    if (DEPTH == 0) begin : g_pass
        assign dout = din;
    end else begin : g_shift
        logic [DEPTH-1:0][2:0] stage;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage <= {DEPTH{IDLE}};
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dout = stage[DEPTH-1];
    end
endmodule

// File: rtl/vga_scan_timing.sv
// rtl/vga_scan_timing.sv - 640x480@60 VGA scan timing generator (pixel enable, x/y, syncs)
// Ports: clk, rst_n (async active-low), bus (vga_scan_timing_if.master).
// Optional feature macro VGA_SCAN_ANIM_EN: when defined, anim_phase toggles every
// ANIM_FRAMES frames; when undefined the frame counter is absent and anim_phase is 0.
module vga_scan_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int H_VISIBLE   = vga_pkg::H_VISIBLE_DEF,
    parameter int H_FP        = vga_pkg::H_FP_DEF,
    parameter int H_SYNC      = vga_pkg::H_SYNC_DEF,
    parameter int H_BP        = vga_pkg::H_BP_DEF,
    parameter int V_VISIBLE   = vga_pkg::V_VISIBLE_DEF,
    parameter int V_FP        = vga_pkg::V_FP_DEF,
    parameter int V_SYNC      = vga_pkg::V_SYNC_DEF,
    parameter int V_BP        = vga_pkg::V_BP_DEF,
    parameter int SYNC_DELAY  = 1,
    parameter int ANIM_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_scan_timing_if.master  bus
);
    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_scan_timing: H_TOTAL/V_TOTAL do not fit 10-bit coordinates");
    end

    logic [DIV_W-1:0] div_cnt;
    logic             pix_en_q;
    logic             frame_tick_q;
    coord_t           x;
    coord_t           y;
    logic             frame_wrap;

    // The last slot of the frame: x and y both roll over on this pixel enable.
    assign frame_wrap = pix_en_q && (x == H_LAST) && (y == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            pix_en_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            x            <= '0;
            y            <= '0;
        end else begin
            pix_en_q     <= (div_cnt == DIV_LAST);
            div_cnt      <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            frame_tick_q <= frame_wrap;
            if (pix_en_q) begin
                if (x == H_LAST) begin
                    x <= '0;
                    y <= (y == V_LAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

`ifdef VGA_SCAN_ANIM_EN
    localparam int FRM_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(ANIM_FRAMES - 1);

    logic [FRM_W-1:0] frame_cnt;
    logic             anim_q;

    // Updated on the same edge that raises frame_tick, so the new phase
    // is already valid during the first pixel of the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            anim_q    <= 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt <= '0;
                anim_q    <= ~anim_q;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign bus.anim_phase = anim_q;
`else
    assign bus.anim_phase = 1'b0;
`endif

    logic [2:0] raw;
    logic [2:0] dly;

    always_comb begin
        raw    = 3'b110;
        raw[2] = !((int'(x) >= HS_START) && (int'(x) < HS_END));
        raw[1] = !((int'(y) >= VS_START) && (int'(y) < VS_END));
        raw[0] = (int'(x) < H_VISIBLE) && (int'(y) < V_VISIBLE);
    end

    // Syncs and blanking are delayed to line up with the selector's registered RGB.
    vga_sync_delay #(
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (raw),
        .dout  (dly)
    );

    assign bus.pix_en     = pix_en_q;
    assign bus.x_ptr      = x;
    assign bus.y_ptr      = y;
    assign bus.frame_tick = frame_tick_q;
    assign bus.hsync      = dly[2];
    assign bus.vsync      = dly[1];
    assign bus.video_on   = dly[0];
endmodule

// File: tb/tb_vga_scan_timing.sv
// tb/tb_vga_scan_timing.sv - self-checking bench for vga_scan_timing (three timing configurations)
module tb_vga_scan_timing;
    typedef struct packed {
        logic       pix_en;
        logic [9:0] x;
        logic [9:0] y;
        logic       video_on;
        logic       hsync;
        logic       vsync;
        logic       frame_tick;
        logic       anim;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // Clock edges since the most recent reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    vga_scan_timing_if bus_a ();
    vga_scan_timing_if bus_b ();
    vga_scan_timing_if bus_c ();

    vga_scan_timing u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    vga_scan_timing #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_DELAY(3), .ANIM_FRAMES(2)
    ) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    vga_scan_timing #(
        .CLK_DIV(3), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_DELAY(0), .ANIM_FRAMES(1)
    ) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    function automatic int slots(int edges, int d);
        return (edges >= 1) ? (edges - 1) / d : 0;
    endfunction

    // Expected outputs after 'edges' clocks since reset release, from the timing rules alone.
    function automatic obs_t model(int edges, int d, int hv, int hfp, int hs, int hbp,
                                   int vv, int vfp, int vs, int vbp, int sd, int af);
        obs_t o;
        int ht, vt, ft, s, m, xd, yd;
        ht = hv + hfp + hs + hbp;
        vt = vv + vfp + vs + vbp;
        ft = ht * vt;
        s  = slots(edges, d);
        o.pix_en     = (edges >= 1) && (edges % d == 0);
        o.x          = 10'(s % ht);
        o.y          = 10'((s / ht) % vt);
        o.frame_tick = (edges >= 1) && (s > 0) && (s % ft == 0) && (slots(edges - 1, d) != s);
`ifdef VGA_SCAN_ANIM_EN
        o.anim       = (((s / ft) / af) % 2) == 1;
`else
        o.anim       = 1'b0;
`endif
        if (edges < sd) begin
            o.hsync = 1'b1; o.vsync = 1'b1; o.video_on = 1'b0;
        end else begin
            m  = slots(edges - sd, d);
            xd = m % ht;
            yd = (m / ht) % vt;
            o.hsync    = !(xd >= hv + hfp && xd < hv + hfp + hs);
            o.vsync    = !(yd >= vv + vfp && yd < vv + vfp + vs);
            o.video_on = (xd < hv) && (yd < vv);
        end
        return o;
    endfunction

    function automatic obs_t grab_a();
        return {bus_a.pix_en, bus_a.x_ptr, bus_a.y_ptr, bus_a.video_on, bus_a.hsync,
                bus_a.vsync, bus_a.frame_tick, bus_a.anim_phase};
    endfunction
    function automatic obs_t grab_b();
        return {bus_b.pix_en, bus_b.x_ptr, bus_b.y_ptr, bus_b.video_on, bus_b.hsync,
                bus_b.vsync, bus_b.frame_tick, bus_b.anim_phase};
    endfunction
    function automatic obs_t grab_c();
        return {bus_c.pix_en, bus_c.x_ptr, bus_c.y_ptr, bus_c.video_on, bus_c.hsync,
                bus_c.vsync, bus_c.frame_tick, bus_c.anim_phase};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s n=%0d got=%0d exp=%0d", name, n, got, exp);
        end
    endtask

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s n=%0d got=%h exp=%h (pix,x,y,vid,hs,vs,ft,anim)", name, n, got, exp);
        end
    endtask

    localparam bit ANIM_ON =
`ifdef VGA_SCAN_ANIM_EN
        1'b1;
`else
        1'b0;
`endif

    // Per-cycle comparison against the model, plus hand-computed pins at known edges.
    always @(negedge clk) begin
        check_obs("A", grab_a(), model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1, 30));
        check_obs("B", grab_b(), model(n, 2, 8, 2, 3, 2, 6, 1, 2, 1, 3, 2));
        check_obs("C", grab_c(), model(n, 3, 8, 2, 3, 2, 6, 1, 2, 1, 0, 1));
        case (n)
            2:    begin check("a_first_pix_en", bus_a.pix_en, 1); check("a_x0", bus_a.x_ptr, 0); end
            3:    begin check("a_pix_en_low", bus_a.pix_en, 0); check("a_x1", bus_a.x_ptr, 1); end
            5:    check("a_x2", bus_a.x_ptr, 2);
            1313: begin check("a_x656", bus_a.x_ptr, 656); check("a_hs_before", bus_a.hsync, 1); end
            1314: check("a_hs_fall", bus_a.hsync, 0);
            1505: begin check("a_x752", bus_a.x_ptr, 752); check("a_hs_still_low", bus_a.hsync, 0); end
            1506: check("a_hs_rise", bus_a.hsync, 1);
            1600: begin check("a_x799", bus_a.x_ptr, 799); check("a_y0", bus_a.y_ptr, 0); end
            1601: begin check("a_wrap_x", bus_a.x_ptr, 0); check("a_wrap_y", bus_a.y_ptr, 1); end
            23:   check("b_hs_d3_before", bus_b.hsync, 1);
            24:   check("b_hs_d3_fall", bus_b.hsync, 0);
            30:   check("c_hs_d0_before", bus_c.hsync, 1);
            31:   begin check("c_x10", bus_c.x_ptr, 10); check("c_hs_d0_fall", bus_c.hsync, 0); end
            213:  check("b_vs_before", bus_b.vsync, 1);
            214:  check("b_vs_fall", bus_b.vsync, 0);
            300:  begin check("b_ft_before", bus_b.frame_tick, 0); check("b_x14", bus_b.x_ptr, 14);
                        check("b_y9", bus_b.y_ptr, 9); end
            301:  begin check("b_frame_tick", bus_b.frame_tick, 1); check("b_anim_f1", bus_b.anim_phase, 0); end
            451:  begin check("c_frame_tick", bus_c.frame_tick, 1); check("c_anim_f1", bus_c.anim_phase, int'(ANIM_ON)); end
            600:  check("b_anim_f1_end", bus_b.anim_phase, 0);
            601:  check("b_anim_f2", bus_b.anim_phase, int'(ANIM_ON));
            default: ;
        endcase
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_hsync", bus_a.hsync, 1);
        check("rst_vsync", bus_a.vsync, 1);
        check("rst_video", bus_a.video_on, 0);
        #1 rst_n = 1'b1;

        repeat (3300) @(posedge clk);
        #2;
        check("pre_rst_x", bus_a.x_ptr, 49);
        check("pre_rst_y", bus_a.y_ptr, 2);
        rst_n = 1'b0;
        #1;
        check("async_x", bus_a.x_ptr, 0);
        check("async_y", bus_a.y_ptr, 0);
        check("async_pix_en", bus_a.pix_en, 0);
        check("async_hsync", bus_a.hsync, 1);
        check("async_vsync", bus_a.vsync, 1);
        check("async_video", bus_a.video_on, 0);
        check("async_b_x", bus_b.x_ptr, 0);

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (1700) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
